// File: rtl/score_display.sv
// -----------------------------------------------------------------------------
// score_display
//   Converts the 24-bit binary score into six decimal digits with a sequential
//   shift-and-add-3 (double-dabble) engine and drives six active-low
//   seven-segment displays. A new conversion starts whenever the score bus
//   differs from the last value that was converted.
//
// Parameters
//   BLANK_LEADING : 1 = blank leading zero digits on hex5..hex1 (hex0 always lit)
//
// Ports
//   clk       : system clock, rising-edge active
//   reset_n   : synchronous reset, ACTIVE-HIGH despite the name
//   score     : unsigned binary score from the accumulator
//   hex0..5   : segment drive, active-low {g,f,e,d,c,b,a}; hex0 = ones digit
//   busy      : high while a conversion is in progress
//   overflow  : high when the last converted score exceeded 999999
// -----------------------------------------------------------------------------
module score_display #(
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] score,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        busy,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [6:0] SEG_ZERO   = 7'b1000000;
  localparam logic [6:0] SEG_UP_RST = BLANK_LEADING ? SEG_BLANK : SEG_ZERO;
  localparam logic [5:0][6:0] HEX_RST =
    {SEG_UP_RST, SEG_UP_RST, SEG_UP_RST, SEG_UP_RST, SEG_UP_RST, SEG_ZERO};

  // Decimal digit to active-low segment pattern.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  state_t          state,    state_next;
  logic [23:0]     last_src, last_src_next;
  logic [23:0]     bin,      bin_next;
  logic [31:0]     bcd,      bcd_next;
  logic [4:0]      cnt,      cnt_next;
  logic [5:0][6:0] hex_q,    hex_next;
  logic            busy_q,   busy_next;
  logic            ovf_q,    ovf_next;

  // Scratch values used only inside the combinational block.
  logic [31:0]     bcd_adj;
  logic [5:0][3:0] digit;
  logic            zero_above;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    last_src_next = last_src;
    bin_next      = bin;
    bcd_next      = bcd;
    cnt_next      = cnt;
    hex_next      = hex_q;
    busy_next     = busy_q;
    ovf_next      = ovf_q;
    digit         = '0;
    zero_above    = 1'b1;

    // Add-3 correction on every BCD nibble that is 5 or more.
    for (int i = 0; i < 8; i++) begin
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3
                                                   : bcd[4*i +: 4];
    end

    case (state)
      IDLE: begin
        if (score != last_src) begin
          last_src_next = score;
          bin_next      = score;
          bcd_next      = '0;
          cnt_next      = '0;
          busy_next     = 1'b1;
          state_next    = SHIFT;
        end
      end

      SHIFT: begin
        // The accumulator's top bit falls off the shift; 8 digits hold the
        // largest 24-bit value so it is always zero here.
        {bcd_next, bin_next} = {bcd_adj, bin} << 1;
        cnt_next             = cnt + 5'd1;
        if (cnt == 5'd23) state_next = DONE;
      end

      DONE: begin
        ovf_next = |bcd[31:24];
        digit    = ovf_next ? 24'h999999 : bcd[23:0];
        // Blank a digit only while every digit above it was also a blank zero.
        for (int i = 5; i >= 1; i--) begin
          if (BLANK_LEADING && zero_above && digit[i] == 4'd0) begin
            hex_next[i] = SEG_BLANK;
          end else begin
            hex_next[i] = seg7(digit[i]);
            zero_above  = 1'b0;
          end
        end
        hex_next[0] = seg7(digit[0]);
        busy_next   = 1'b0;
        state_next  = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (reset_n) begin  // active-high: a 1 on reset_n aborts any conversion
      state    <= IDLE;
      last_src <= '0;
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      hex_q    <= HEX_RST;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_next;
      last_src <= last_src_next;
      bin      <= bin_next;
      bcd      <= bcd_next;
      cnt      <= cnt_next;
      hex_q    <= hex_next;
      busy_q   <= busy_next;
      ovf_q    <= ovf_next;
    end
  end

  assign hex0     = hex_q[0];
  assign hex1     = hex_q[1];
  assign hex2     = hex_q[2];
  assign hex3     = hex_q[3];
  assign hex4     = hex_q[4];
  assign hex5     = hex_q[5];
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule
